// File: rtl/program_loader.sv
// ============================================================================
//  Module   : program_loader
//  Function : Packs a little-endian byte stream (32-bit word count, then
//             that many words) into program memory at the text base, holding
//             the CPU in reset until the image has been written.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int                NBits        = 32,
    parameter int                MEMORY_DEPTH = 512,
    parameter logic [NBits-1:0]  BASE_ADDR    = 32'h0040_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             restart,
    output logic             mem_we,
    output logic [NBits-1:0] mem_addr,
    output logic [NBits-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [NBits-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [NBits-1:0] c_depth = NBits'(MEMORY_DEPTH);
    localparam logic [NBits-1:0] c_one   = {{(NBits-1){1'b0}}, 1'b1};
    localparam logic [NBits-1:0] c_zero  = '0;

    state_t           r_state;
    logic [1:0]       r_byte_cnt;
    logic [NBits-1:0] r_shift;
    logic [NBits-1:0] r_word_cnt;
    logic [NBits-1:0] r_words_loaded;
    logic             r_byte_ready;
    logic             r_mem_we;
    logic [NBits-1:0] r_mem_addr;
    logic [NBits-1:0] r_mem_wdata;
    logic             r_cpu_hold;
    logic             r_done;
    logic             r_error;

    logic             w_take;
    logic [NBits-1:0] w_shifted;
    logic [NBits-1:0] w_loaded_next;

    // Ready is forced low combinationally while reset is held.
    assign byte_ready    = r_byte_ready & reset;
    assign w_take        = byte_valid & byte_ready;
    assign w_shifted     = {byte_data, r_shift[NBits-1:8]};
    assign w_loaded_next = r_words_loaded + c_one;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_HDR;
            r_byte_cnt     <= 2'd0;
            r_shift        <= c_zero;
            r_word_cnt     <= c_zero;
            r_words_loaded <= c_zero;
            r_byte_ready   <= 1'b1;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= BASE_ADDR;
            r_mem_wdata    <= c_zero;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_take) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= w_shifted;
                        if (r_byte_cnt == 2'd3) begin
                            r_word_cnt <= w_shifted;
                            if (w_shifted == c_zero) begin
                                r_state      <= S_DONE;
                                r_byte_ready <= 1'b0;
                                r_done       <= 1'b1;
                                r_cpu_hold   <= 1'b0;
                            end else if (w_shifted > c_depth) begin
                                r_state      <= S_ERR;
                                r_byte_ready <= 1'b0;
                                r_error      <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= w_shifted;
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= BASE_ADDR + {r_words_loaded[NBits-3:0], 2'b00};
                            r_mem_wdata  <= w_shifted;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_we       <= 1'b0;
                    r_words_loaded <= w_loaded_next;
                    if (w_loaded_next == r_word_cnt) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state      <= S_DATA;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    // Memory contents are left intact on a reload.
                    if (restart) begin
                        r_state        <= S_HDR;
                        r_byte_cnt     <= 2'd0;
                        r_words_loaded <= c_zero;
                        r_byte_ready   <= 1'b1;
                        r_mem_addr     <= BASE_ADDR;
                        r_cpu_hold     <= 1'b1;
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module   : tb_program_loader
//  Function : Self-checking bench for program_loader: stream-level model
//             compared every cycle, plus literal expectations per scenario.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam logic [31:0] c_base = 32'h0040_0000;
    localparam int          c_depth = 512;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    int errors = 0;
    int checks = 0;

    program_loader #(
        .NBits(32), .MEMORY_DEPTH(c_depth), .BASE_ADDR(c_base)
    ) dut (
        .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream-level model: what must be visible after each clock edge.
    int          m_bytes = 0;
    logic [31:0] m_n = 0;
    logic [31:0] m_word = 0;
    logic [31:0] m_loaded = 0;
    logic        m_done = 0;
    logic        m_err = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = c_base;
    logic [31:0] m_data = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = reset && !m_done && !m_err && !m_we;
        chk("byte_ready", {31'd0, byte_ready}, {31'd0, exp_ready});
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("error", {31'd0, error}, {31'd0, m_err});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !m_done});
        chk("words_loaded", words_loaded, m_loaded);
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (!reset) begin
            m_bytes = 0; m_loaded = 0; m_done = 0; m_err = 0;
            m_we = 0; m_addr = c_base; m_data = 0;
        end else if ((m_done || m_err) && restart) begin
            m_bytes = 0; m_loaded = 0; m_done = 0; m_err = 0; m_addr = c_base;
        end else if (m_we) begin
            m_we = 0;
            m_loaded = m_loaded + 1;
            if (m_loaded == m_n) m_done = 1;
        end else if (byte_valid && exp_ready) begin
            m_word[8*(m_bytes%4) +: 8] = byte_data;
            if (m_bytes == 3) begin
                m_n = m_word;
                if (m_n == 0) m_done = 1;
                else if (m_n > c_depth) m_err = 1;
            end else if (m_bytes > 3 && m_bytes % 4 == 3) begin
                m_we = 1;
                m_addr = c_base + 32'(4 * ((m_bytes - 4) / 4));
                m_data = m_word;
            end
            m_bytes++;
        end
    end

    // Drivers: all start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        tries = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                byte_valid = 1'b0;
                break;
            end
            tries++;
            if (tries > 200) begin
                chk("handshake_timeout", 32'd0, 32'd1);
                byte_valid = 1'b0;
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_s1(input int maxgap);
        send_word(32'd2, maxgap);
        send_word(32'h2008_0005, maxgap);
        send_word(32'h2109_0001, maxgap);
    endtask

    task automatic check_s1_log(input string tag);
        chk({tag, "_writes"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk({tag, "_addr0"}, log_addr[0], 32'h0040_0000);
            chk({tag, "_data0"}, log_data[0], 32'h2008_0005);
            chk({tag, "_addr1"}, log_addr[1], 32'h0040_0004);
            chk({tag, "_data1"}, log_data[1], 32'h2109_0001);
        end
    endtask

    logic [31:0] save_addr[$];
    logic [31:0] save_data[$];

    initial begin
        reset = 1'b0; byte_data = 8'h00; byte_valid = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", mem_addr, 32'h0040_0000);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Two-word image.
        clear_log();
        send_s1(0);
        wait_done();
        check_s1_log("s1");
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_hold", {31'd0, cpu_hold}, 32'd0);
        chk("s1_words", words_loaded, 32'd2);

        // Reload one word; restart mid-load must be ignored.
        pulse_restart();
        chk("s6_hold", {31'd0, cpu_hold}, 32'd1);
        chk("s6_done", {31'd0, done}, 32'd0);
        chk("s6_words", words_loaded, 32'd0);
        clear_log();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        pulse_restart();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_done();
        chk("s6_writes", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("s6_addr", log_addr[0], 32'h0040_0000);
            chk("s6_data", log_data[0], 32'hDEAD_BEEF);
        end
        chk("s6_words_end", words_loaded, 32'd1);

        // Empty image.
        pulse_restart();
        clear_log();
        send_word(32'd0, 0);
        @(negedge clk);
        chk("s2_done", {31'd0, done}, 32'd1);
        chk("s2_hold", {31'd0, cpu_hold}, 32'd0);
        @(posedge clk); #1;
        chk("s2_writes", 32'(log_addr.size()), 32'd0);

        // Oversized header, then bytes offered into ERR.
        pulse_restart();
        clear_log();
        send_word(32'd513, 0);
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'(i);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        chk("s3_error", {31'd0, error}, 32'd1);
        chk("s3_hold", {31'd0, cpu_hold}, 32'd1);
        chk("s3_writes", 32'(log_addr.size()), 32'd0);

        // Largest legal image.
        pulse_restart();
        clear_log();
        send_word(32'd512, 0);
        for (int i = 0; i < 512; i++) send_word(32'hA500_0000 ^ 32'(i), 0);
        wait_done();
        chk("s3_full_writes", 32'(log_addr.size()), 32'd512);
        if (log_addr.size() == 512) begin
            chk("s3_last_addr", log_addr[511], 32'h0040_07FC);
            chk("s3_last_data", log_data[511], 32'hA500_01FF);
        end
        chk("s3_full_words", words_loaded, 32'd512);

        // Back-to-back bytes, then the same image with random gaps.
        pulse_restart();
        clear_log();
        send_word(32'd3, 0);
        send_word(32'h1111_2222, 0);
        send_word(32'h3333_4444, 0);
        send_word(32'h5555_6666, 0);
        wait_done();
        save_addr = log_addr;
        save_data = log_data;
        chk("s4_writes", 32'(save_addr.size()), 32'd3);
        if (save_data.size() == 3) chk("s4_data2", save_data[2], 32'h5555_6666);
        pulse_restart();
        clear_log();
        send_word(32'd3, 3);
        send_word(32'h1111_2222, 3);
        send_word(32'h3333_4444, 3);
        send_word(32'h5555_6666, 3);
        wait_done();
        chk("s4_gap_writes", 32'(log_addr.size()), 32'(save_addr.size()));
        for (int i = 0; i < log_addr.size() && i < save_addr.size(); i++) begin
            chk("s4_gap_addr", log_addr[i], save_addr[i]);
            chk("s4_gap_data", log_data[i], save_data[i]);
        end

        // Reset in the middle of a load.
        pulse_restart();
        clear_log();
        send_word(32'd2, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("s5_words", words_loaded, 32'd0);
        chk("s5_addr", mem_addr, 32'h0040_0000);
        chk("s5_wdata", mem_wdata, 32'd0);
        chk("s5_hold", {31'd0, cpu_hold}, 32'd1);
        chk("s5_ready", {31'd0, byte_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        send_s1(2);
        wait_done();
        check_s1_log("s5");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
